// File: rtl/uart_alu_parser.sv
// Packet parser between UART RX and the ALU datapath.
// Decodes a 4-byte header, then echoes bytes, gathers LE words, or drains the payload.
module uart_alu_parser #(
  parameter logic [7:0]  OP_ECHO = 8'hEC,
  parameter logic [7:0]  OP_ADD  = 8'hA0,
  parameter logic [7:0]  OP_MUL  = 8'hA1,
  parameter logic [7:0]  OP_DIV  = 8'hA2,
  parameter int unsigned MIN_OPS = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  op_o,
  output logic [31:0] word_o,
  output logic        word_valid_o,
  output logic        word_first_o,
  output logic        word_last_o,
  input  logic        word_ready_i,
  output logic [7:0]  echo_data_o,
  output logic        echo_valid_o,
  input  logic        echo_ready_i,
  output logic        err_o
);

  typedef enum logic [2:0] {
    S_OPCODE,
    S_RSVD,
    S_LEN_LO,
    S_LEN_HI,
    S_ECHO,
    S_GATHER,
    S_EMIT,
    S_DRAIN
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [7:0]  op_hold;
  logic [7:0]  len_lo;
  logic [15:0] cnt;
  logic [1:0]  byte_idx;
  logic        first_pend;
  logic        err_d;

  logic [15:0] len;
  logic [15:0] pay;
  logic [13:0] nops;
  logic        is_alu;
  logic        ops_ok;
  logic        accept;
  logic        cnt_last;

  assign len      = {rx_data_i, len_lo};
  assign pay      = len - 16'd4;
  assign nops     = pay[15:2];
  assign is_alu   = (op_hold == OP_ADD) || (op_hold == OP_MUL)
                 || (op_hold == OP_DIV);
  assign ops_ok   = (op_hold == OP_DIV) ? (nops == 14'd2)
                  : ({18'd0, nops} >= MIN_OPS);
  assign cnt_last = (cnt == 16'd1);

  // ECHO is a zero-latency pass-through gated by the TX path
  assign rx_ready_o   = (state_q == S_EMIT) ? 1'b0
                      : (state_q == S_ECHO) ? echo_ready_i
                      : 1'b1;
  assign accept       = rx_valid_i & rx_ready_o;
  assign echo_valid_o = (state_q == S_ECHO) & rx_valid_i;
  assign echo_data_o  = (state_q == S_ECHO) ? rx_data_i : 8'h00;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_OPCODE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_OPCODE: if (accept) state_d = S_RSVD;
      S_RSVD:   if (accept) state_d = S_LEN_LO;
      S_LEN_LO: if (accept) state_d = S_LEN_HI;
      S_LEN_HI: begin
        if (accept) begin
          if (len < 16'd4) begin
            err_d   = 1'b1;
            state_d = S_OPCODE;
          end else if (pay == 16'd0) begin
            state_d = S_OPCODE;
          end else if (op_hold == OP_ECHO) begin
            state_d = S_ECHO;
          end else if (is_alu && (pay[1:0] == 2'd0) && ops_ok) begin
            state_d = S_GATHER;
          end else begin
            err_d   = 1'b1;
            state_d = S_DRAIN;
          end
        end
      end
      S_ECHO:   if (accept && cnt_last) state_d = S_OPCODE;
      S_GATHER: if (accept && byte_idx == 2'd3) state_d = S_EMIT;
      S_EMIT: begin
        if (word_ready_i)
          state_d = word_last_o ? S_OPCODE : S_GATHER;
      end
      S_DRAIN:  if (accept && cnt_last) state_d = S_OPCODE;
      default:  state_d = S_OPCODE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_hold      <= 8'h00;
      len_lo       <= 8'h00;
      cnt          <= 16'd0;
      byte_idx     <= 2'd0;
      first_pend   <= 1'b0;
      op_o         <= 8'h00;
      word_o       <= 32'd0;
      word_valid_o <= 1'b0;
      word_first_o <= 1'b0;
      word_last_o  <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      err_o <= err_d;
      unique case (state_q)
        S_OPCODE: if (accept) op_hold <= rx_data_i;
        S_LEN_LO: if (accept) len_lo <= rx_data_i;
        S_LEN_HI: begin
          if (accept) begin
            op_o       <= op_hold;
            cnt        <= pay;
            byte_idx   <= 2'd0;
            first_pend <= 1'b1;
          end
        end
        S_GATHER: begin
          if (accept) begin
            word_o   <= {rx_data_i, word_o[31:8]};
            cnt      <= cnt - 16'd1;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              word_valid_o <= 1'b1;
              word_first_o <= first_pend;
              word_last_o  <= cnt_last;
              first_pend   <= 1'b0;
            end
          end
        end
        S_EMIT: begin
          if (word_ready_i) begin
            word_valid_o <= 1'b0;
            word_first_o <= 1'b0;
            word_last_o  <= 1'b0;
          end
        end
        S_ECHO, S_DRAIN: if (accept) cnt <= cnt - 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_alu_parser.sv
// Bench for uart_alu_parser: directed packets plus random ones,
// checked against a packet-level reference model.
module tb_uart_alu_parser;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  op;
  logic [31:0] word;
  logic        word_valid, word_first, word_last;
  logic        word_ready = 1'b0;
  logic [7:0]  echo_data;
  logic        echo_valid;
  logic        echo_ready = 1'b0;
  logic        err;

  int checks = 0;
  int errors = 0;
  bit force_low = 1'b0;
  bit gaps = 1'b1;
  bit stuck = 1'b0;

  logic [33:0] obs_w[$];
  logic [33:0] exp_w[$];
  logic [7:0]  obs_e[$];
  logic [7:0]  exp_e[$];
  int obs_err = 0;
  int exp_err = 0;

  uart_alu_parser dut (
    .clk_i(clk), .rst_i(rst),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .op_o(op), .word_o(word), .word_valid_o(word_valid),
    .word_first_o(word_first), .word_last_o(word_last),
    .word_ready_i(word_ready),
    .echo_data_o(echo_data), .echo_valid_o(echo_valid),
    .echo_ready_i(echo_ready), .err_o(err)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    #1;
    word_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    echo_ready = ($urandom_range(0, 3) != 0);
  end

  // Inputs change just after posedge, so negedge state is what the next edge sees
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (word_valid && word_ready) obs_w.push_back({word_first, word_last, word});
      if (echo_valid && echo_ready) obs_e.push_back(echo_data);
      if (err) obs_err++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask

  function automatic void model(input bq_t p);
    logic [7:0]  opc;
    int          len, pay, n;
    opc = p[0];
    len = {16'd0, p[3], p[2]};
    if (len < 4) begin
      exp_err++;
      return;
    end
    pay = len - 4;
    if (pay == 0) return;
    if (opc == 8'hEC) begin
      for (int i = 0; i < pay; i++) exp_e.push_back(p[4 + i]);
      return;
    end
    n = pay / 4;
    if ((opc == 8'hA0 || opc == 8'hA1 || opc == 8'hA2) && pay % 4 == 0
        && (opc == 8'hA2 ? n == 2 : n >= 2)) begin
      for (int k = 0; k < n; k++)
        exp_w.push_back({k == 0, k == n - 1,
                         p[4*k+7], p[4*k+6], p[4*k+5], p[4*k+4]});
    end else begin
      exp_err++;
    end
  endfunction

  task automatic send_byte(input logic [7:0] b);
    int n;
    if (stuck) return;
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rx_ready && n < 1000);
    if (!rx_ready) begin
      stuck = 1'b1;
      chk("rx_ready_timeout", 64'(rx_ready), 64'd1);
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_pkt(input bq_t p);
    foreach (p[i]) begin
      send_byte(p[i]);
      if (gaps && $urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic settle();
    int n;
    n = 0;
    while ((obs_w.size() < exp_w.size() || obs_e.size() < exp_e.size())
           && n < 400) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_nwords"}, 64'(obs_w.size()), 64'(exp_w.size()));
    while (obs_w.size() > 0 && exp_w.size() > 0)
      chk({tag, "_word"}, 64'(obs_w.pop_front()), 64'(exp_w.pop_front()));
    chk({tag, "_necho"}, 64'(obs_e.size()), 64'(exp_e.size()));
    while (obs_e.size() > 0 && exp_e.size() > 0)
      chk({tag, "_echo"}, 64'(obs_e.pop_front()), 64'(exp_e.pop_front()));
    chk({tag, "_err"}, 64'(obs_err), 64'(exp_err));
    obs_w.delete();
    exp_w.delete();
    obs_e.delete();
    exp_e.delete();
    obs_err = 0;
    exp_err = 0;
  endtask

  task automatic run_pkt(input string tag, input bq_t p);
    model(p);
    send_pkt(p);
    settle();
    compare_all(tag);
    chk({tag, "_op"}, 64'(op), 64'(p[0]));
  endtask

  task automatic check_reset_state(input string tag);
    @(negedge clk);
    chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd1);
    chk({tag, "_wvalid"}, 64'({word_valid, word_first, word_last}), 64'd0);
    chk({tag, "_op"}, 64'(op), 64'd0);
    chk({tag, "_word"}, 64'(word), 64'd0);
    chk({tag, "_echo"}, 64'({echo_valid, echo_data}), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic bq_t rand_pkt();
    bq_t        p;
    logic [7:0] opc;
    int         len;
    case ($urandom_range(0, 4))
      0: opc = 8'hEC;
      1: opc = 8'hA0;
      2: opc = 8'hA1;
      3: opc = 8'hA2;
      default: opc = 8'($urandom);
    endcase
    case ($urandom_range(0, 2))
      0: len = 4 + 4 * $urandom_range(1, 4);
      1: len = $urandom_range(0, 20);
      default: len = 12;
    endcase
    p.push_back(opc);
    p.push_back(8'($urandom));
    p.push_back(8'(len));
    p.push_back(8'(len >> 8));
    for (int i = 4; i < len; i++) p.push_back(8'($urandom));
    return p;
  endfunction

  initial begin
    bq_t         p;
    bq_t         q;
    logic [31:0] held;
    int          n;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("reset");

    run_pkt("echo", '{8'hEC, 8'h00, 8'h07, 8'h00, 8'h61, 8'h62, 8'h63});

    run_pkt("add", '{8'hA0, 8'h00, 8'h0C, 8'h00,
                     8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00});

    p = '{8'hA2, 8'h00, 8'h0C, 8'h00,
          8'h64, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    model(p);
    force_low = 1'b1;
    @(posedge clk);
    #1;
    fork
      send_pkt(p);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!word_valid && n < 200);
        chk("stall_valid", 64'(word_valid), 64'd1);
        held = word;
        repeat (5) begin
          @(negedge clk);
          chk("stall_word", 64'(word), 64'(held));
          chk("stall_rx_ready", 64'(rx_ready), 64'd0);
        end
        force_low = 1'b0;
      end
    join
    settle();
    compare_all("div_stall");
    chk("div_op", 64'(op), 64'hA2);

    p = '{8'hA1, 8'h00, 8'h09, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    q = '{8'hA0, 8'h00, 8'h0C, 8'h00,
          8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12};
    model(p);
    model(q);
    send_pkt(p);
    send_pkt(q);
    settle();
    compare_all("drain");
    chk("drain_op", 64'(op), 64'hA0);

    p = '{8'hEC, 8'h00, 8'h02, 8'h00};
    model(p);
    send_pkt(p);
    settle();
    compare_all("short_len");
    run_pkt("after_short", '{8'hA1, 8'h00, 8'h0C, 8'h00,
                             8'h03, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00});

    p = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h11, 8'h22};
    send_pkt(p);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_state("mid_rst");
    settle();
    compare_all("mid_rst_q");
    run_pkt("after_rst", '{8'hA0, 8'h00, 8'h10, 8'h00,
                           8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
                           8'h09, 8'h0A, 8'h0B, 8'h0C});

    p = '{8'hA0, 8'h00, 8'hFF, 8'hFF};
    for (int i = 0; i < 65531; i++) p.push_back(8'($urandom));
    gaps = 1'b0;
    run_pkt("max_len", p);
    gaps = 1'b1;
    run_pkt("after_max", '{8'hA0, 8'h00, 8'h0C, 8'h00,
                           8'hAA, 8'h00, 8'h00, 8'h00, 8'hBB, 8'h00, 8'h00, 8'h00});

    for (int r = 0; r < 25; r++) begin
      p = rand_pkt();
      run_pkt("rand", p);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
